// File: rtl/spi_tx_phy.sv
// ---------------------------------------------------------------------------
// spi_tx_phy
//   Transmit-only SPI PHY for an LCD panel, SPI mode 0 (SCK idles low, data
//   changes on the falling edge, sampled by the panel on the rising edge),
//   MSB first. One 8- or 32-bit word per transfer. Every pin is a flop
//   output.
//
// Parameters
//   CLK_DIV       SCK half-period in clk cycles (1..255)
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   spi_mosi      [31:0] word to send (narrow transfers use [7:0])
//   spi_begin     transfer request, sampled while idle
//   spi_wide      1 = 32-bit transfer, 0 = 8-bit transfer
//   spi_cs        chip-select level wanted while idle (1 = deselect)
//   lcd_data_cmd  D/C level latched at transfer start (1 = data)
//   spi_busy      transfer in progress
//   lcd_sck       serial clock pin
//   lcd_sdo       serial data pin
//   lcd_cs_n      chip-select pin, active low
//   lcd_dc        data/command pin
// ---------------------------------------------------------------------------
module spi_tx_phy #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] spi_mosi,
    input  logic        spi_begin,
    input  logic        spi_wide,
    input  logic        spi_cs,
    input  logic        lcd_data_cmd,
    output logic        spi_busy,
    output logic        lcd_sck,
    output logic        lcd_sdo,
    output logic        lcd_cs_n,
    output logic        lcd_dc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    // Last count value of each SCK half-period.
    localparam logic [7:0] HALF_TC = 8'(CLK_DIV - 1);

    state_t      state_q,    state_d;
    logic [31:0] shreg_q,    shreg_d;
    logic [5:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic        busy_q,     busy_d;
    logic        sck_q,      sck_d;
    logic        sdo_q,      sdo_d;
    logic        cs_n_q,     cs_n_d;
    logic        dc_q,       dc_d;

    logic        half_done;
    logic [5:0]  bit_cnt_dec;
    logic [31:0] shreg_shift;
    logic [31:0] load_word;

    assign half_done   = (half_cnt_q == HALF_TC);
    // Saturating decrement: the bit counter never wraps below zero.
    assign bit_cnt_dec = (bit_cnt_q != 6'd0) ? (bit_cnt_q - 6'd1) : 6'd0;
    assign shreg_shift = {shreg_q[30:0], 1'b0};
    // Narrow words are left-justified so bit 31 is always the next bit out.
    assign load_word   = spi_wide ? spi_mosi : {spi_mosi[7:0], 24'h0};

    // NOTE: every variable gets its default (hold) value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        half_cnt_d = half_cnt_q;
        busy_d     = busy_q;
        sck_d      = sck_q;
        sdo_d      = sdo_q;
        dc_d       = dc_q;

        unique case (state_q)
            ST_IDLE: begin
                sck_d      = 1'b0;
                sdo_d      = 1'b0;
                half_cnt_d = 8'd0;
                if (spi_begin) begin
                    shreg_d   = load_word;
                    bit_cnt_d = spi_wide ? 6'd32 : 6'd8;
                    dc_d      = lcd_data_cmd;
                    busy_d    = 1'b1;
                    // First data bit must already be on the pin for the LOW phase.
                    sdo_d     = load_word[31];
                    state_d   = ST_LOW;
                end
            end

            ST_LOW: begin
                sck_d = 1'b0;
                sdo_d = shreg_q[31];
                if (half_done) begin
                    half_cnt_d = 8'd0;
                    sck_d      = 1'b1;
                    state_d    = ST_HIGH;
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
            end

            ST_HIGH: begin
                sck_d = 1'b1;
                if (half_done) begin
                    half_cnt_d = 8'd0;
                    shreg_d    = shreg_shift;
                    bit_cnt_d  = bit_cnt_dec;
                    sck_d      = 1'b0;
                    if (bit_cnt_dec != 6'd0) begin
                        // Falling SCK edge: present the next bit together with it.
                        sdo_d   = shreg_shift[31];
                        state_d = ST_LOW;
                    end else begin
                        sdo_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sck_d   = 1'b0;
                sdo_d   = 1'b0;
            end
        endcase

        // Chip select is forced low for the whole transfer and otherwise follows
        // the requested level, so a deselect queued with the last word takes
        // effect on the edge that ends that word.
        cs_n_d = busy_d ? 1'b0 : spi_cs;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed above regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 32'h0;
            bit_cnt_q  <= 6'd0;
            half_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            sdo_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            dc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            half_cnt_q <= half_cnt_d;
            busy_q     <= busy_d;
            sck_q      <= sck_d;
            sdo_q      <= sdo_d;
            cs_n_q     <= cs_n_d;
            dc_q       <= dc_d;
        end
    end

    assign spi_busy = busy_q;
    assign lcd_sck  = sck_q;
    assign lcd_sdo  = sdo_q;
    assign lcd_cs_n = cs_n_q;
    assign lcd_dc   = dc_q;

endmodule
